// File: rtl/bkm_bus_pkg.sv
// Shared constants, FSM state type and request-length helper for the BVM-A
// option-slot host bus master.
package bkm_bus_pkg;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;

  localparam logic [7:0] CMD_IRQ        = 8'h02;
  localparam logic [7:0] CMD_INIT       = 8'h10;
  localparam logic [7:0] CMD_SLOT0_BASE = 8'h20;
  localparam logic [7:0] CMD_SLOT1_BASE = 8'h30;
  localparam logic [7:0] CMD_SLOT2_BASE = 8'h40;
  localparam logic [7:0] CMD_OFS_ID      = 8'h00;
  localparam logic [7:0] CMD_OFS_VIDEO   = 8'h01;
  localparam logic [7:0] CMD_OFS_PREPARE = 8'h02;
  localparam logic [7:0] CMD_OFS_SERIAL  = 8'h03;

  localparam logic [7:0] REG_SLOT_NUM = 8'h03;
  localparam logic [7:0] REG_INIT0    = 8'h40;
  localparam logic [7:0] REG_INIT1    = 8'h41;
  localparam logic [7:0] REG_INIT2    = 8'h42;
  localparam logic [7:0] REG_INIT3    = 8'h43;
  localparam logic [7:0] REG_VIDEO0   = 8'h00;
  localparam logic [7:0] REG_VIDEO1   = 8'h10;
  localparam logic [7:0] REG_VIDEO2   = 8'h31;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC0  = 3'd1,
    S_CMD    = 3'd2,
    S_SYNC_R = 3'd3,
    S_REG    = 3'd4,
    S_DATA   = 3'd5,
    S_SYNC1  = 3'd6
  } bkm_state_e;

  // A length code of 3 behaves exactly like 2 (cmd+reg+data).
  function automatic logic [1:0] norm_len(input logic [1:0] len);
    return (len == 2'd3) ? 2'd2 : len;
  endfunction

endpackage

// File: rtl/bkm_bus_cycle_gen.sv
// Strobe timing for one bus cycle: HALF clocks low then HALF clocks high on clk_rw.
// o_cyc_end marks the last high clock; it is both the read-sample point and the FSM advance.
module bkm_bus_cycle_gen #(
  parameter int HALF = 25
) (
  input  logic clk_50mhz_in,
  input  logic reset,
  input  logic i_run,
  output logic o_clk_rw,
  output logic o_cyc_end
);

  localparam logic [7:0] LAST = 8'(HALF - 1);

  logic [7:0] r_cnt;
  logic       r_high;
  logic       w_wrap;

  assign w_wrap = (r_cnt == LAST);

  always_ff @(posedge clk_50mhz_in) begin
    if (reset || !i_run) begin
      r_cnt  <= 8'd0;
      r_high <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= 8'd0;
      r_high <= ~r_high;
    end else begin
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  assign o_clk_rw  = r_high;
  assign o_cyc_end = i_run && r_high && w_wrap;

endmodule

// File: rtl/bkm_host_bus_master.sv
// Host-side initiator for the BVM-A option-slot bus: turns one local request
// into a sync/cmd/reg/data strobe sequence and captures read data and the slot IRQ.
//
// state  | meaning
// IDLE   | waiting for a request, bus parked (not driven)
// SYNC0  | leading sync, idle byte
// CMD    | command byte
// SYNC_R | sync between command and register cycles
// REG    | register byte
// DATA   | write data out, or read data in with bus released
// SYNC1  | trailing sync returns the slave to idle, then respond
module bkm_host_bus_master
  import bkm_bus_pkg::*;
#(
  parameter int HALF        = 25,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_50mhz_in,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_len,
  input  logic       req_write,
  input  logic       req_sel,
  input  logic [7:0] req_cmd,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       irq_pending,
  output logic       clk_rw,
  output logic       ax_d,
  output logic       r_wx,
  output logic       slot_x_int_x,
  output logic [7:0] data_out_x,
  output logic       data_oe,
  input  logic [7:0] data_in_x,
  input  logic       int_x
);

  bkm_state_e r_state, w_state_nxt;

  logic [1:0] r_len;
  logic       r_write;
  logic [7:0] r_cmd, r_reg, r_wdata;

  logic       r_ax_d, r_rwx, r_oe, r_slot_x, r_rsp_valid;
  logic [7:0] r_dout_x, r_rdata;

  logic [SYNC_STAGES-1:0] r_int_sync;
  logic [7:0]             r_din_sync [SYNC_STAGES];

  logic       w_run, w_cyc_end, w_clk_rw, w_accept, w_done;
  logic       w_ax_d, w_rwx, w_oe;
  logic [7:0] w_byte;

  assign w_run    = (r_state != S_IDLE);
  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_done   = (r_state == S_SYNC1) && w_cyc_end;

  bkm_bus_cycle_gen #(.HALF(HALF)) u_cycle_gen (
    .clk_50mhz_in (clk_50mhz_in),
    .reset        (reset),
    .i_run        (w_run),
    .o_clk_rw     (w_clk_rw),
    .o_cyc_end    (w_cyc_end)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_state_nxt = S_SYNC0;
      S_SYNC0:  if (w_cyc_end) w_state_nxt = S_CMD;
      S_CMD:    if (w_cyc_end) w_state_nxt = (r_len == 2'd0) ? S_SYNC1 : S_SYNC_R;
      S_SYNC_R: if (w_cyc_end) w_state_nxt = S_REG;
      S_REG:    if (w_cyc_end) w_state_nxt = (r_len == 2'd1) ? S_SYNC1 : S_DATA;
      S_DATA:   if (w_cyc_end) w_state_nxt = S_SYNC1;
      S_SYNC1:  if (w_cyc_end) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Bus lines are decoded from the next state and registered, so they only
  // move on the first clock of a cycle's low phase.
  always_comb begin
    w_ax_d = 1'b0;
    w_rwx  = 1'b1;
    w_oe   = 1'b1;
    w_byte = IDLE_BYTE;
    case (w_state_nxt)
      S_IDLE: w_oe = 1'b0;
      S_CMD: begin
        w_rwx  = 1'b0;
        w_byte = r_cmd;
      end
      S_REG: begin
        w_ax_d = 1'b1;
        w_rwx  = ~((r_len == 2'd2) && !r_write);
        w_byte = r_reg;
      end
      S_DATA: begin
        w_ax_d = 1'b1;
        if (r_write) begin
          w_rwx  = 1'b0;
          w_byte = r_wdata;
        end else begin
          w_oe   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50mhz_in) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len       <= 2'd0;
      r_write     <= 1'b0;
      r_cmd       <= 8'h00;
      r_reg       <= 8'h00;
      r_wdata     <= 8'h00;
      r_ax_d      <= 1'b0;
      r_rwx       <= 1'b1;
      r_oe        <= 1'b0;
      r_dout_x    <= ~IDLE_BYTE;
      r_slot_x    <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_ax_d      <= w_ax_d;
      r_rwx       <= w_rwx;
      r_oe        <= w_oe;
      r_dout_x    <= ~w_byte;
      r_rsp_valid <= w_done;
      if (w_accept) begin
        r_len    <= norm_len(req_len);
        r_write  <= req_write;
        r_cmd    <= req_cmd;
        r_reg    <= req_reg;
        r_wdata  <= req_wdata;
        r_slot_x <= ~req_sel;
      end else if (w_done) begin
        r_slot_x <= 1'b1;
      end
      if ((r_state == S_DATA) && !r_write && w_cyc_end)
        r_rdata <= ~r_din_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk_50mhz_in) begin
    if (reset) begin
      r_int_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) r_din_sync[i] <= 8'hFF;
    end else begin
      r_int_sync[0] <= int_x;
      r_din_sync[0] <= data_in_x;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_int_sync[i] <= r_int_sync[i-1];
        r_din_sync[i] <= r_din_sync[i-1];
      end
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rdata;
  assign irq_pending  = ~r_int_sync[SYNC_STAGES-1];
  assign clk_rw       = w_clk_rw;
  assign ax_d         = r_ax_d;
  assign r_wx         = r_rwx;
  assign slot_x_int_x = r_slot_x;
  assign data_out_x   = r_dout_x;
  assign data_oe      = r_oe;

endmodule

// File: tb/tb_bkm_host_bus_master.sv
// Directed bench for bkm_host_bus_master; a strobe monitor stands in for the slot responder.
module tb_bkm_host_bus_master;
  import bkm_bus_pkg::*;

  localparam int HALF = 4;
  localparam int SYNC = 2;
  localparam int CYC  = 2 * HALF;

  logic       clk_50mhz_in = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_len = 2'd0;
  logic       req_write = 1'b0;
  logic       req_sel = 1'b0;
  logic [7:0] req_cmd = 8'h00, req_reg = 8'h00, req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       irq_pending, clk_rw, ax_d, r_wx, slot_x_int_x, data_oe;
  logic [7:0] data_out_x;
  logic [7:0] data_in_x = 8'hFF;
  logic       int_x = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  // {logical byte, ax_d, r_wx, data_oe, slot_x_int_x} at each clk_rw rise
  logic [11:0] q_strb[$];

  always #5 clk_50mhz_in = ~clk_50mhz_in;

  always @(posedge clk_rw)
    q_strb.push_back({~data_out_x, ax_d, r_wx, data_oe, slot_x_int_x});

  bkm_host_bus_master #(.HALF(HALF), .SYNC_STAGES(SYNC)) dut (
    .clk_50mhz_in (clk_50mhz_in),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_len      (req_len),
    .req_write    (req_write),
    .req_sel      (req_sel),
    .req_cmd      (req_cmd),
    .req_reg      (req_reg),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .irq_pending  (irq_pending),
    .clk_rw       (clk_rw),
    .ax_d         (ax_d),
    .r_wx         (r_wx),
    .slot_x_int_x (slot_x_int_x),
    .data_out_x   (data_out_x),
    .data_oe      (data_oe),
    .data_in_x    (data_in_x),
    .int_x        (int_x)
  );

  // Issues one request and waits for rsp_valid; lat counts clocks from the
  // accepting edge, oe_lo counts clocks of the transaction with data_oe low.
  task automatic run_req(input logic [1:0] len, input logic wr, input logic sel,
                         input logic [7:0] cmd, input logic [7:0] rg, input logic [7:0] wd,
                         output int lat, output int oe_lo);
    bit done;
    @(negedge clk_50mhz_in);
    q_strb.delete();
    req_len = len; req_write = wr; req_sel = sel;
    req_cmd = cmd; req_reg = rg; req_wdata = wd;
    req_valid = 1'b1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL ready_idle got=%b exp=1", req_ready);
    else n_pass++;
    @(posedge clk_50mhz_in);
    @(negedge clk_50mhz_in);
    req_valid = 1'b0;
    oe_lo = (data_oe === 1'b0) ? 1 : 0;
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL ready_busy got=%b exp=0", req_ready);
    else n_pass++;
    lat = 0;
    done = 0;
    while (!done && lat < 1000) begin
      @(posedge clk_50mhz_in);
      lat++;
      @(negedge clk_50mhz_in);
      if (rsp_valid === 1'b1) done = 1;
      else if (data_oe === 1'b0) oe_lo++;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL rsp_timeout got=none exp=rsp_valid within 1000 clocks");
    end else begin
      n_checks++;
      if (slot_x_int_x !== 1'b1) $display("FAIL slot_release got=%b exp=1", slot_x_int_x);
      else n_pass++;
      @(posedge clk_50mhz_in);
      @(negedge clk_50mhz_in);
      n_checks++;
      if (rsp_valid !== 1'b0) $display("FAIL rsp_pulse got=%b exp=0", rsp_valid);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({clk_rw, ax_d, r_wx, slot_x_int_x, data_oe, req_ready, rsp_valid, irq_pending} !== 8'b0011_0100)
      $display("FAIL reset_ctrl got=%b exp=00110100",
               {clk_rw, ax_d, r_wx, slot_x_int_x, data_oe, req_ready, rsp_valid, irq_pending});
    else n_pass++;
    n_checks++;
    if ({data_out_x, rsp_rdata} !== 16'h0000)
      $display("FAIL reset_data got=%h exp=0000", {data_out_x, rsp_rdata});
    else n_pass++;
  endtask

  task automatic test_reset_mid_cmd();
    int seen;
    @(negedge clk_50mhz_in);
    req_len = 2'd2; req_write = 1'b1; req_sel = 1'b1;
    req_cmd = CMD_INIT; req_reg = REG_SLOT_NUM; req_wdata = 8'h02;
    req_valid = 1'b1;
    @(posedge clk_50mhz_in);
    @(negedge clk_50mhz_in);
    req_valid = 1'b0;
    repeat (HALF + HALF + HALF) @(negedge clk_50mhz_in);
    n_checks++;
    if ({clk_rw, data_oe, data_out_x} !== {1'b1, 1'b1, ~CMD_INIT})
      $display("FAIL midcmd_bus got=%b%b%h exp=11%h", clk_rw, data_oe, data_out_x, ~CMD_INIT);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk_50mhz_in);
    @(negedge clk_50mhz_in);
    n_checks++;
    if ({clk_rw, data_oe, req_ready, rsp_valid, slot_x_int_x, data_out_x} !== {5'b00101, 8'h00})
      $display("FAIL abort_state got=%b%b%b%b%b_%h exp=00101_00",
               clk_rw, data_oe, req_ready, rsp_valid, slot_x_int_x, data_out_x);
    else n_pass++;
    repeat (2) @(posedge clk_50mhz_in);
    @(negedge clk_50mhz_in);
    reset = 1'b0;
    seen = 0;
    repeat (8 * CYC) begin
      @(negedge clk_50mhz_in);
      if (rsp_valid === 1'b1 || clk_rw === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL abort_quiet got=%0d exp=0 active clocks", seen);
    else n_pass++;
  endtask

  task automatic test_write();
    int lat, oe_lo;
    logic [11:0] e [6];
    logic [11:0] g;
    e[0] = {8'hFF, 4'b0110}; e[1] = {8'h10, 4'b0010}; e[2] = {8'hFF, 4'b0110};
    e[3] = {8'h03, 4'b1110}; e[4] = {8'h02, 4'b1010}; e[5] = {8'hFF, 4'b0110};
    run_req(2'd2, 1'b1, 1'b1, CMD_INIT, REG_SLOT_NUM, 8'h02, lat, oe_lo);
    n_checks++;
    if (lat !== 6 * CYC) $display("FAIL wr_latency got=%0d exp=%0d", lat, 6 * CYC);
    else n_pass++;
    n_checks++;
    if (q_strb.size() !== 6) $display("FAIL wr_strobes got=%0d exp=6", q_strb.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < q_strb.size(); i++) begin
      g = q_strb[i];
      n_checks++;
      if (g !== e[i]) $display("FAIL wr_cycle%0d got=%h exp=%h", i, g, e[i]);
      else n_pass++;
    end
    n_checks++;
    if (oe_lo !== 0 || rsp_rdata !== 8'h00)
      $display("FAIL wr_oe_rdata got=%0d/%h exp=0/00", oe_lo, rsp_rdata);
    else n_pass++;
  endtask

  task automatic test_read();
    int lat, oe_lo;
    logic [11:0] e [6];
    logic [11:0] g;
    e[0] = {8'hFF, 4'b0111}; e[1] = {8'h20, 4'b0011}; e[2] = {8'hFF, 4'b0111};
    e[3] = {8'h00, 4'b1011}; e[4] = {8'h00, 4'b1101}; e[5] = {8'hFF, 4'b0111};
    data_in_x = 8'h77;
    run_req(2'd2, 1'b0, 1'b0, CMD_SLOT0_BASE, REG_VIDEO0, 8'hA5, lat, oe_lo);
    n_checks++;
    if (rsp_rdata !== 8'h88) $display("FAIL rd_data got=%h exp=88", rsp_rdata);
    else n_pass++;
    n_checks++;
    if (lat !== 6 * CYC || oe_lo !== CYC)
      $display("FAIL rd_timing got=%0d/%0d exp=%0d/%0d", lat, oe_lo, 6 * CYC, CYC);
    else n_pass++;
    n_checks++;
    if (q_strb.size() !== 6) $display("FAIL rd_strobes got=%0d exp=6", q_strb.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < q_strb.size(); i++) begin
      g = q_strb[i];
      if (e[i][1] == 1'b0) g[11:4] = 8'h00;
      n_checks++;
      if (g !== e[i]) $display("FAIL rd_cycle%0d got=%h exp=%h", i, g, e[i]);
      else n_pass++;
    end
  endtask

  task automatic test_cmd_only();
    int lat, oe_lo;
    logic [11:0] e [3];
    e[0] = {8'hFF, 4'b0111}; e[1] = {8'h02, 4'b0011}; e[2] = {8'hFF, 4'b0111};
    data_in_x = 8'h00;
    run_req(2'd0, 1'b0, 1'b0, CMD_IRQ, 8'h55, 8'h66, lat, oe_lo);
    n_checks++;
    if (lat !== 3 * CYC) $display("FAIL cmd_latency got=%0d exp=%0d", lat, 3 * CYC);
    else n_pass++;
    n_checks++;
    if (q_strb.size() !== 3) $display("FAIL cmd_strobes got=%0d exp=3", q_strb.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < q_strb.size(); i++) begin
      n_checks++;
      if (q_strb[i] !== e[i]) $display("FAIL cmd_cycle%0d got=%h exp=%h", i, q_strb[i], e[i]);
      else n_pass++;
    end
    n_checks++;
    if (rsp_rdata !== 8'h88) $display("FAIL cmd_rdata_hold got=%h exp=88", rsp_rdata);
    else n_pass++;
  endtask

  task automatic test_lengths();
    int lat, oe_lo;
    run_req(2'd1, 1'b0, 1'b0, CMD_SLOT1_BASE, REG_VIDEO1, 8'h00, lat, oe_lo);
    n_checks++;
    if (lat !== 5 * CYC || q_strb.size() !== 5)
      $display("FAIL len1 got=%0d/%0d exp=%0d/5", lat, q_strb.size(), 5 * CYC);
    else n_pass++;
    n_checks++;
    if (q_strb.size() > 3 && q_strb[3] !== {REG_VIDEO1, 4'b1111})
      $display("FAIL len1_reg got=%h exp=%h", q_strb[3], {REG_VIDEO1, 4'b1111});
    else n_pass++;
    run_req(2'd3, 1'b1, 1'b0, CMD_SLOT2_BASE, REG_INIT0, 8'h3C, lat, oe_lo);
    n_checks++;
    if (lat !== 6 * CYC || q_strb.size() !== 6)
      $display("FAIL len3 got=%0d/%0d exp=%0d/6", lat, q_strb.size(), 6 * CYC);
    else n_pass++;
  endtask

  task automatic test_irq();
    @(negedge clk_50mhz_in);
    int_x = 1'b0;
    @(negedge clk_50mhz_in);
    n_checks++;
    if (irq_pending !== 1'b0) $display("FAIL irq_early got=%b exp=0", irq_pending);
    else n_pass++;
    @(negedge clk_50mhz_in);
    n_checks++;
    if (irq_pending !== 1'b1) $display("FAIL irq_set got=%b exp=1", irq_pending);
    else n_pass++;
    int_x = 1'b1;
    @(negedge clk_50mhz_in);
    n_checks++;
    if (irq_pending !== 1'b1) $display("FAIL irq_hold got=%b exp=1", irq_pending);
    else n_pass++;
    @(negedge clk_50mhz_in);
    n_checks++;
    if (irq_pending !== 1'b0) $display("FAIL irq_clear got=%b exp=0", irq_pending);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int  n, lat;
    bit  done;
    logic [7:0] eb [6];
    eb[0] = 8'hFF; eb[1] = 8'h02; eb[2] = 8'hFF; eb[3] = 8'hFF; eb[4] = 8'h02; eb[5] = 8'hFF;
    @(negedge clk_50mhz_in);
    q_strb.delete();
    req_len = 2'd0; req_write = 1'b0; req_sel = 1'b1; req_cmd = CMD_IRQ;
    req_valid = 1'b1;
    done = 0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk_50mhz_in);
      n++;
      if (rsp_valid === 1'b1) done = 1;
    end
    n_checks++;
    if (!done) $display("FAIL b2b_first got=none exp=rsp_valid within 200 clocks");
    else n_pass++;
    @(negedge clk_50mhz_in);
    req_valid = 1'b0;
    n_checks++;
    if ({rsp_valid, req_ready, slot_x_int_x, data_oe} !== 4'b0001)
      $display("FAIL b2b_start got=%b exp=0001", {rsp_valid, req_ready, slot_x_int_x, data_oe});
    else n_pass++;
    lat = 0;
    done = 0;
    while (!done && lat < 200) begin
      @(posedge clk_50mhz_in);
      lat++;
      @(negedge clk_50mhz_in);
      if (rsp_valid === 1'b1) done = 1;
    end
    n_checks++;
    if (lat !== 3 * CYC) $display("FAIL b2b_latency got=%0d exp=%0d", lat, 3 * CYC);
    else n_pass++;
    repeat (3 * CYC) @(negedge clk_50mhz_in);
    n_checks++;
    if (q_strb.size() !== 6) $display("FAIL b2b_strobes got=%0d exp=6", q_strb.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < q_strb.size(); i++) begin
      n_checks++;
      if (q_strb[i][11:4] !== eb[i]) $display("FAIL b2b_byte%0d got=%h exp=%h", i, q_strb[i][11:4], eb[i]);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk_50mhz_in);
    @(negedge clk_50mhz_in);
    test_reset();
    reset = 1'b0;
    @(negedge clk_50mhz_in);
    test_reset();
    test_reset_mid_cmd();
    test_write();
    test_read();
    test_cmd_only();
    test_lengths();
    test_irq();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
